// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side signals of decode_queue; master drives fetch/issue, slave is the queue.
// branch_cond: 0 NONE,1 LTZ,2 GEZ,3 GTZ,4 EQ,5 NE,6 LEZ. alu_optr codes are listed in decode_queue.sv.
interface decode_queue_if #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_ins;
    logic [PC_WIDTH-1:0] in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [31:0]         out_ins;
    logic                alu_src_a;
    logic                alu_src_b;
    logic                alu_overflow;
    logic                reg_dest;
    logic                ext_op;
    logic [2:0]          branch_cond;
    logic [4:0]          alu_optr;
    logic                write_reg;
    logic                write_mem;
    logic                read_mem;
    logic                jmp;
    logic                branch;
    logic                write_cp0;
    logic                link;
    logic                illegal;
    logic [1:0]          write_reg_src;
    logic [CW-1:0]       count;

    modport master (
        output in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ins, alu_src_a, alu_src_b, alu_overflow,
               reg_dest, ext_op, branch_cond, alu_optr, write_reg, write_mem, read_mem,
               jmp, branch, write_cp0, link, illegal, write_reg_src, count
    );

    modport slave (
        input  in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ins, alu_src_a, alu_src_b, alu_overflow,
               reg_dest, ext_op, branch_cond, alu_optr, write_reg, write_mem, read_mem,
               jmp, branch, write_cp0, link, illegal, write_reg_src, count
    );
endinterface

// File: rtl/decode_queue.sv
// MIPS-I decoder feeding a DEPTH-entry queue of decoded ops; push-to-head latency 1 cycle when empty.
// in_ready drops at full regardless of out_ready; flush empties the queue. DECODE_CP0_EN enables MFC0/MTC0.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] BC_NONE = 3'd0, BC_LTZ = 3'd1, BC_GEZ = 3'd2, BC_GTZ = 3'd3,
                           BC_EQ = 3'd4, BC_NE = 3'd5, BC_LEZ = 3'd6;
    localparam logic [4:0] A_NONE = 5'd0, A_PLUS = 5'd1, A_PLUSU = 5'd2, A_MINUS = 5'd3,
                           A_MINUSU = 5'd4, A_AND = 5'd5, A_OR = 5'd6, A_XOR = 5'd7,
                           A_NOR = 5'd8, A_LT = 5'd9, A_LTU = 5'd10, A_TIMES = 5'd11,
                           A_TIMESU = 5'd12, A_DIV = 5'd13, A_DIVU = 5'd14, A_EQ = 5'd15,
                           A_NE = 5'd16;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                           OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                           OP_COP0 = 6'h10, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
                           OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef struct packed {
        logic       alu_src_a;
        logic       alu_src_b;
        logic       alu_overflow;
        logic       reg_dest;
        logic       ext_op;
        logic [2:0] branch_cond;
        logic [4:0] alu_optr;
        logic       write_reg;
        logic       write_mem;
        logic       read_mem;
        logic       jmp;
        logic       branch;
        logic       write_cp0;
        logic       link;
        logic       illegal;
        logic [1:0] write_reg_src;
    } ctrl_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    assign op    = q.in_ins[31:26];
    assign funct = q.in_ins[5:0];
    assign rt    = q.in_ins[20:16];
`ifdef DECODE_CP0_EN
    logic [4:0] rs;
    assign rs = q.in_ins[25:21];
`endif

    ctrl_t dec;
    logic  legal;

    always_comb begin
        dec           = '0;
        dec.alu_src_b = 1'b1;
        dec.reg_dest  = 1'b1;
        legal         = 1'b1;
        case (op)
            OP_SPECIAL: begin
                dec.alu_src_b = 1'b0;
                dec.reg_dest  = 1'b0;
                dec.write_reg = 1'b1;
                case (funct)
                    F_SLL, F_SRL, F_SRA: dec.alu_src_a = 1'b1;
                    F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin end
                    F_JR:    begin dec.write_reg = 1'b0; dec.jmp = 1'b1; end
                    F_JALR:  begin dec.jmp = 1'b1; dec.link = 1'b1; end
                    F_MULT:  begin dec.write_reg = 1'b0; dec.alu_optr = A_TIMES; end
                    F_MULTU: begin dec.write_reg = 1'b0; dec.alu_optr = A_TIMESU; end
                    F_DIV:   begin dec.write_reg = 1'b0; dec.alu_optr = A_DIV; end
                    F_DIVU:  begin dec.write_reg = 1'b0; dec.alu_optr = A_DIVU; end
                    F_ADD:   begin dec.alu_optr = A_PLUS; dec.alu_overflow = 1'b1; end
                    F_ADDU:  dec.alu_optr = A_PLUSU;
                    F_SUB:   begin dec.alu_optr = A_MINUS; dec.alu_overflow = 1'b1; end
                    F_SUBU:  dec.alu_optr = A_MINUSU;
                    F_AND:   dec.alu_optr = A_AND;
                    F_OR:    dec.alu_optr = A_OR;
                    F_XOR:   dec.alu_optr = A_XOR;
                    F_NOR:   dec.alu_optr = A_NOR;
                    F_SLT:   dec.alu_optr = A_LT;
                    F_SLTU:  dec.alu_optr = A_LTU;
                    default: legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                dec.branch = 1'b1;
                case (rt)
                    5'd0:    dec.branch_cond = BC_LTZ;
                    5'd1:    dec.branch_cond = BC_GEZ;
                    5'd16:   begin dec.branch_cond = BC_LTZ; dec.link = 1'b1; dec.write_reg = 1'b1; end
                    5'd17:   begin dec.branch_cond = BC_GEZ; dec.link = 1'b1; dec.write_reg = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_J:     dec.jmp = 1'b1;
            OP_JAL:   begin dec.jmp = 1'b1; dec.link = 1'b1; dec.write_reg = 1'b1; end
            OP_BEQ:   begin dec.alu_src_b = 1'b0; dec.branch = 1'b1; dec.branch_cond = BC_EQ; dec.alu_optr = A_EQ; end
            OP_BNE:   begin dec.alu_src_b = 1'b0; dec.branch = 1'b1; dec.branch_cond = BC_NE; dec.alu_optr = A_NE; end
            OP_BLEZ:  begin dec.branch = 1'b1; dec.branch_cond = BC_LEZ; end
            OP_BGTZ:  begin dec.branch = 1'b1; dec.branch_cond = BC_GTZ; end
            OP_ADDI:  begin dec.alu_optr = A_PLUS; dec.alu_overflow = 1'b1; dec.ext_op = 1'b1; dec.write_reg = 1'b1; end
            OP_ADDIU: begin dec.alu_optr = A_PLUSU; dec.ext_op = 1'b1; dec.write_reg = 1'b1; end
            OP_SLTI:  begin dec.alu_optr = A_LT; dec.ext_op = 1'b1; dec.write_reg = 1'b1; end
            OP_SLTIU: begin dec.alu_optr = A_LTU; dec.ext_op = 1'b1; dec.write_reg = 1'b1; end
            OP_ANDI:  begin dec.alu_optr = A_AND; dec.write_reg = 1'b1; end
            OP_ORI:   begin dec.alu_optr = A_OR; dec.write_reg = 1'b1; end
            OP_XORI:  begin dec.alu_optr = A_XOR; dec.write_reg = 1'b1; end
            OP_LUI:   dec.write_reg = 1'b1;
            OP_COP0: begin
`ifdef DECODE_CP0_EN
                if (q.in_ins[10:3] != 8'd0) begin
                    legal = 1'b0;
                end else if (rs == 5'd0) begin
                    dec.write_reg     = 1'b1;
                    dec.write_reg_src = 2'd2;
                end else if (rs == 5'd4) begin
                    dec.write_cp0 = 1'b1;
                end else begin
                    legal = 1'b0;
                end
`else
                legal = 1'b0;
`endif
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.alu_optr      = A_PLUS;
                dec.ext_op        = 1'b1;
                dec.read_mem      = 1'b1;
                dec.write_reg     = 1'b1;
                dec.write_reg_src = 2'd1;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.alu_optr  = A_PLUS;
                dec.ext_op    = 1'b1;
                dec.write_mem = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal words keep their queue slot but carry no side-effecting control.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       cnt;
    logic                push;
    logic                pop;
    logic                not_empty;
    ctrl_t               ctrl_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
    logic [31:0]         ins_mem  [DEPTH];

    assign not_empty  = (cnt != '0);
    assign q.in_ready = (cnt != CW'(DEPTH));
    assign q.out_valid = not_empty;
    assign q.count    = cnt;
    assign push       = q.in_valid & q.in_ready & ~flush & rst_n;
    assign pop        = not_empty & q.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= dec;
            pc_mem[wr_ptr]   <= q.in_pc;
            ins_mem[wr_ptr]  <= q.in_ins;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    ctrl_t               head;
    logic [PC_WIDTH-1:0] head_pc;
    logic [31:0]         head_ins;

    always_comb begin
        head     = '0;
        head_pc  = '0;
        head_ins = '0;
        if (not_empty) begin
            head     = ctrl_mem[rd_ptr];
            head_pc  = pc_mem[rd_ptr];
            head_ins = ins_mem[rd_ptr];
        end
    end

    assign q.out_pc        = head_pc;
    assign q.out_ins       = head_ins;
    assign q.alu_src_a     = head.alu_src_a;
    assign q.alu_src_b     = head.alu_src_b;
    assign q.alu_overflow  = head.alu_overflow;
    assign q.reg_dest      = head.reg_dest;
    assign q.ext_op        = head.ext_op;
    assign q.branch_cond   = head.branch_cond;
    assign q.alu_optr      = head.alu_optr;
    assign q.write_reg     = head.write_reg;
    assign q.write_mem     = head.write_mem;
    assign q.read_mem      = head.read_mem;
    assign q.jmp           = head.jmp;
    assign q.branch        = head.branch;
    assign q.write_cp0     = head.write_cp0;
    assign q.link          = head.link;
    assign q.illegal       = head.illegal;
    assign q.write_reg_src = head.write_reg_src;
endmodule
